// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Single-port video-memory arbiter shared between the scanout engine and a CPU.
// The scanout has priority on every cycle. A pending CPU access is denied at
// most STARVE_LIMIT consecutive cycles; after that it is granted and the
// colliding scanout read is reported as a miss.
//
// Ports
//   clock_25        single clock, all registers update on its rising edge
//   reset           synchronous, active-high reset
//   vid_req         scanout read request for this cycle
//   vid_address     scanout read address
//   vid_data        scanout read data (straight from mem_rdata)
//   vid_valid       registered: vid_data carries the read granted last cycle
//   vid_miss        registered: last cycle's scanout request was preempted
//   vid_miss_count  saturating count of preempted scanout requests
//   cpu_req         CPU access request (sampled only when idle)
//   cpu_we          CPU write enable
//   cpu_address     CPU address
//   cpu_wdata       CPU write data
//   cpu_rdata       registered CPU read data
//   cpu_ready       one-cycle completion pulse
//   cpu_busy        high while a CPU access is in flight
//   mem_address     address to the synchronous RAM
//   mem_wdata       write data to the RAM
//   mem_we          write strobe to the RAM
//   mem_rdata       RAM read data, one cycle after the address
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int AW           = 18,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          clock_25,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_address,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    output logic          vid_miss,
    output logic [7:0]    vid_miss_count,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ready,
    output logic          cpu_busy,
    output logic [AW-1:0] mem_address,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } cpu_state_t;

    // Denial limit held in the same 4-bit width as the wait counter.
    localparam logic [3:0] STARVE_CNT = 4'(STARVE_LIMIT);

    cpu_state_t    state_r;
    logic [3:0]    wait_cnt_r;
    logic          req_we_r;
    logic [AW-1:0] req_addr_r;
    logic [7:0]    req_wdata_r;
    logic [7:0]    cpu_rdata_r;
    logic          cpu_ready_r;
    logic          cpu_busy_r;
    logic          vid_valid_r;
    logic          vid_miss_r;
    logic [7:0]    vid_miss_count_r;

    logic          starved_s;
    logic          cpu_grant_s;
    logic          vid_grant_s;

    assign starved_s = (wait_cnt_r == STARVE_CNT);

    // Per-cycle grant decision: the CPU wins only from PEND on a free bus or
    // once starved; otherwise any scanout request gets the bus.
    always_comb begin
        cpu_grant_s = 1'b0;
        vid_grant_s = 1'b0;
        if (reset) begin
            cpu_grant_s = 1'b0;
            vid_grant_s = 1'b0;
        end else begin
            if ((state_r == ST_PEND) && (!vid_req || starved_s)) begin
                cpu_grant_s = 1'b1;
            end else begin
                cpu_grant_s = 1'b0;
            end
            vid_grant_s = vid_req & ~cpu_grant_s;
        end
    end

    // With no CPU grant the RAM address follows the scanout, granted or not.
    assign mem_address = cpu_grant_s ? req_addr_r  : vid_address;
    assign mem_wdata   = cpu_grant_s ? req_wdata_r : 8'h00;
    assign mem_we      = cpu_grant_s & req_we_r;
    assign vid_data    = mem_rdata;

    // CPU access sequencer: latch request, wait for the bus, capture data, ack.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            req_we_r    <= 1'b0;
            req_addr_r  <= {AW{1'b0}};
            req_wdata_r <= 8'h00;
            cpu_rdata_r <= 8'h00;
            cpu_ready_r <= 1'b0;
            cpu_busy_r  <= 1'b0;
        end else begin
            cpu_ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req) begin
                        req_we_r    <= cpu_we;
                        req_addr_r  <= cpu_address;
                        req_wdata_r <= cpu_wdata;
                        wait_cnt_r  <= 4'd0;
                        cpu_busy_r  <= 1'b1;
                        state_r     <= ST_PEND;
                    end else begin
                        cpu_busy_r  <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (cpu_grant_s) begin
                        wait_cnt_r <= 4'd0;
                        state_r    <= ST_DATA;
                    end else begin
                        // Not granted here means the scanout took the bus.
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                ST_DATA: begin
                    // RAM output now holds the word addressed in the grant cycle.
                    if (!req_we_r) begin
                        cpu_rdata_r <= mem_rdata;
                    end
                    cpu_ready_r <= 1'b1;
                    state_r     <= ST_ACK;
                end
                ST_ACK: begin
                    cpu_busy_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    cpu_busy_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Scanout status: valid after a video grant, miss when the CPU preempted it.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            vid_valid_r      <= 1'b0;
            vid_miss_r       <= 1'b0;
            vid_miss_count_r <= 8'h00;
        end else begin
            vid_valid_r <= vid_grant_s;
            vid_miss_r  <= vid_req & cpu_grant_s;
            if (vid_req && cpu_grant_s && (vid_miss_count_r != 8'hFF)) begin
                vid_miss_count_r <= vid_miss_count_r + 8'd1;
            end
        end
    end

    assign cpu_rdata      = cpu_rdata_r;
    assign cpu_ready      = cpu_ready_r;
    assign cpu_busy       = cpu_busy_r;
    assign vid_valid      = vid_valid_r;
    assign vid_miss       = vid_miss_r;
    assign vid_miss_count = vid_miss_count_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Randomised and directed stimulus for vram_arbiter. A transaction-level model
// predicts, from the per-cycle inputs, when each CPU access is granted (first
// pending cycle with a free bus or after STARVE_LIMIT denials) and what every
// scanout request yields; expected responses go into queues that a separate
// monitor drains as the DUT presents cpu_ready / vid_valid / vid_miss.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW    = 18;
    localparam int LIMIT = 15;

    logic          clock_25;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_address;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic          vid_miss;
    logic [7:0]    vid_miss_count;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ready;
    logic          cpu_busy;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;

    vram_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clock_25       (clock_25),
        .reset          (reset),
        .vid_req        (vid_req),
        .vid_address    (vid_address),
        .vid_data       (vid_data),
        .vid_valid      (vid_valid),
        .vid_miss       (vid_miss),
        .vid_miss_count (vid_miss_count),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_address    (cpu_address),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .cpu_busy       (cpu_busy),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata)
    );

    initial begin
        clock_25 = 1'b0;
        forever #20 clock_25 = ~clock_25;
    end

    // Power-on RAM contents; 0x00100 holds 0xA5 for the idle-bus read.
    function automatic logic [7:0] init_val(input logic [17:0] a);
        if (a == 18'h00100) return 8'hA5;
        return a[7:0] ^ {a[13:8], a[17:16]} ^ 8'h3C;
    endfunction

    // Synchronous RAM seen by the DUT.
    bit [7:0] ram_data [0:(1<<AW)-1];
    bit       ram_ok   [0:(1<<AW)-1];
    always @(posedge clock_25) begin
        mem_rdata <= ram_ok[mem_address] ? ram_data[mem_address] : init_val(mem_address);
        if (mem_we) begin
            ram_data[mem_address] <= mem_wdata;
            ram_ok[mem_address]   <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int cyc; logic [7:0] data; } cpu_exp_t;
    typedef struct { int cyc; logic [1:0] kind; logic [7:0] data; } vid_exp_t;  // kind {valid,miss}

    cpu_exp_t exp_cpu[$];
    vid_exp_t exp_vid[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_wr [int];
    bit         job_valid = 1'b0;
    bit         job_granted;
    int         job_start, job_free, denials;
    logic       job_we;
    logic [17:0] job_addr;
    logic [7:0] job_wdata;
    logic [7:0] model_rdata = 8'h00;
    int         model_miss  = 0;
    logic        exp_we_c, exp_busy_c;
    logic [17:0] exp_addr_c;
    logic [7:0]  exp_wdata_c;

    function automatic logic [7:0] ref_read(input logic [17:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return init_val(a);
    endfunction

    function automatic void model_cycle();
        bit cpu_g;
        cpu_g = 1'b0;
        if (job_valid && job_granted && (cyc >= job_free)) job_valid = 1'b0;
        exp_busy_c  = job_valid && (cyc > job_start);
        exp_we_c    = 1'b0;
        exp_addr_c  = vid_address;
        exp_wdata_c = 8'h00;
        if (reset) begin
            while (exp_cpu.size() != 0 && exp_cpu[$].cyc > cyc) void'(exp_cpu.pop_back());
            while (exp_vid.size() != 0 && exp_vid[$].cyc > cyc) void'(exp_vid.pop_back());
            job_valid   = 1'b0;
            model_miss  = 0;
            model_rdata = 8'h00;
        end else begin
            if (job_valid && !job_granted && (cyc > job_start)) begin
                if (!vid_req || denials == LIMIT) cpu_g = 1'b1;
                else denials++;
            end
            if (cpu_g) begin
                exp_addr_c = job_addr;
                exp_we_c   = job_we;
                if (job_we) begin
                    exp_wdata_c = job_wdata;
                    ref_wr[int'(job_addr)] = job_wdata;
                end else begin
                    model_rdata = ref_read(job_addr);
                end
                exp_cpu.push_back('{cyc + 2, model_rdata});
                job_granted = 1'b1;
                job_free    = cyc + 3;
                if (vid_req) begin
                    if (model_miss < 255) model_miss++;
                    exp_vid.push_back('{cyc + 1, 2'b01, 8'(model_miss)});
                end
            end else if (vid_req) begin
                exp_vid.push_back('{cyc + 1, 2'b10, ref_read(vid_address)});
            end
            if (!job_valid && cpu_req) begin
                job_valid   = 1'b1;
                job_granted = 1'b0;
                job_start   = cyc;
                denials     = 0;
                job_we      = cpu_we;
                job_addr    = cpu_address;
                job_wdata   = cpu_wdata;
            end
        end
    endfunction

    // ---------------- monitor ----------------
    cpu_exp_t ce_m;
    vid_exp_t ve_m;
    logic [1:0] obs_m;
    initial begin
        forever begin
            @(negedge clock_25);
            if (mon_en) begin
                chk("mem_we", mem_we, exp_we_c);
                chk("mem_address", mem_address, exp_addr_c);
                if (exp_we_c) chk("mem_wdata", mem_wdata, exp_wdata_c);
                chk("cpu_busy", cpu_busy, exp_busy_c);
                if (cpu_ready) begin
                    if (exp_cpu.size() == 0) begin
                        chk("cpu_ready_spurious", cpu_ready, 1'b0);
                    end else begin
                        ce_m = exp_cpu.pop_front();
                        chk("cpu_ready_cycle", cyc, ce_m.cyc);
                        chk("cpu_rdata", cpu_rdata, ce_m.data);
                    end
                end else if (exp_cpu.size() != 0 && exp_cpu[0].cyc <= cyc) begin
                    ce_m = exp_cpu.pop_front();
                    chk("cpu_ready_missing", cpu_ready, 1'b1);
                end
                obs_m = {vid_valid, vid_miss};
                if (obs_m != 2'b00) begin
                    if (exp_vid.size() == 0) begin
                        chk("vid_spurious", obs_m, 2'b00);
                    end else begin
                        ve_m = exp_vid.pop_front();
                        chk("vid_cycle", cyc, ve_m.cyc);
                        chk("vid_kind", obs_m, ve_m.kind);
                        if (ve_m.kind == 2'b10) chk("vid_data", vid_data, ve_m.data);
                        else chk("vid_miss_count", vid_miss_count, ve_m.data);
                    end
                end else if (exp_vid.size() != 0 && exp_vid[0].cyc <= cyc) begin
                    ve_m = exp_vid.pop_front();
                    chk("vid_missing", obs_m, ve_m.kind);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic vr, input logic [17:0] va,
                        input logic cr, input logic cw, input logic [17:0] ca,
                        input logic [7:0] cd);
        reset       = r;
        vid_req     = vr;
        vid_address = va;
        cpu_req     = cr;
        cpu_we      = cw;
        cpu_address = ca;
        cpu_wdata   = cd;
        model_cycle();
        @(posedge clock_25);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 8'h00);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_cpu_ready"}, cpu_ready, 1'b0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 8'h00);
        chk({tag, "_cpu_busy"}, cpu_busy, 1'b0);
        chk({tag, "_vid_valid"}, vid_valid, 1'b0);
        chk({tag, "_vid_miss"}, vid_miss, 1'b0);
        chk({tag, "_vid_miss_count"}, vid_miss_count, 8'h00);
    endtask

    initial begin
        step(1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 8'h00);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 18'h5, 1'b1, 1'b1, 18'h9, 8'h12);
        step(1'b1, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 8'h00);
        check_cleared("reset");

        // Idle-bus read of the preloaded 0x00100.
        step(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 18'h00100, 8'h00);
        idle(6);

        // Write under alternating video requests, then read it back.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'(i % 2), 18'($urandom_range(0, 63)), 1'(i == 0), 1'b1, 18'h0002A, 8'h77);
        chk("alt_miss_count", vid_miss_count, 8'h00);
        step(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 18'h0002A, 8'h00);
        idle(6);

        // Starvation: video always requesting.
        step(1'b0, 1'b1, 18'h3, 1'b1, 1'b0, 18'h00003, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 18'($urandom_range(0, 63)), 1'b0, 1'b0, 18'h0, 8'h00);
        idle(4);
        chk("starve_miss_count", vid_miss_count, 8'h01);

        // Back-to-back reads with cpu_req held high.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 18'(8 + i), 8'h00);
        idle(6);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7),
                 18'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 18'($urandom_range(0, 63)), 8'($urandom));
        idle(5);

        // Reset while a write is still pending behind the scanout.
        step(1'b0, 1'b1, 18'h1, 1'b1, 1'b1, 18'h00015, 8'hEE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 18'h2, 1'b0, 1'b0, 18'h0, 8'h00);
        step(1'b1, 1'b1, 18'h2, 1'b0, 1'b0, 18'h0, 8'h00);
        check_cleared("pend_reset");
        idle(4);
        step(1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 18'h00015, 8'h00);
        idle(6);

        // Saturation: keep forcing preemptions well past 255.
        for (int i = 0; i < 5000; i++) step(1'b0, 1'b1, 18'($urandom_range(0, 63)), 1'b1, 1'b0, 18'($urandom_range(0, 63)), 8'h00);
        idle(5);
        chk("sat_miss_count", vid_miss_count, 8'hFF);

        idle(5);
        chk("cpu_queue_left", exp_cpu.size(), 0);
        chk("vid_queue_left", exp_vid.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: AW, 18, video-memory byte-address width.
REQ-002 Parameter: STARVE_LIMIT, 15, maximum consecutive cycles a pending CPU access may be denied; legal range 1..15.
REQ-003 clock_25  in  1  single clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vid_req  in  1  scanout requests a read this cycle.
REQ-006 vid_address  in  AW  scanout read address.
REQ-007 vid_data  out  8  read data for the scanout; combinationally equals mem_rdata.
REQ-008 vid_valid  out  1  registered; vid_data is valid this cycle.
REQ-009 vid_miss  out  1  registered; one-cycle pulse marking a scanout request that was preempted.
REQ-010 vid_miss_count  out  8  saturating count of preempted scanout requests.
REQ-011 cpu_req  in  1  CPU access request.
REQ-012 cpu_we  in  1  CPU write enable.
REQ-013 cpu_address  in  AW  CPU address.
REQ-014 cpu_wdata  in  8  CPU write data.
REQ-015 cpu_rdata  out  8  registered CPU read data.
REQ-016 cpu_ready  out  1  one-cycle completion pulse.
REQ-017 cpu_busy  out  1  high whenever the FSM is not in IDLE.
REQ-018 mem_address  out  AW  combinational address to the synchronous RAM.
REQ-019 mem_wdata  out  8  combinational write data to the RAM.
REQ-020 mem_we  out  1  combinational write strobe to the RAM.
REQ-021 mem_rdata  in  8  RAM read data; valid one cycle after its address was presented.

Function
REQ-022 Arbitration is per cycle, with exactly one grant (VID, CPU or none) per cycle.
REQ-023 CPU FSM states: IDLE, PEND, DATA, ACK.
REQ-024 IDLE: when cpu_req=1, latch cpu_we, cpu_address and cpu_wdata into a request register and go to PEND; no memory grant occurs in IDLE.
REQ-025 PEND: grant the CPU when vid_req=0 or wait_cnt==STARVE_LIMIT, otherwise grant video and increment wait_cnt.
REQ-026 PEND after a CPU grant: go to DATA and clear wait_cnt.
REQ-027 CPU grant drives mem_address and mem_wdata from the latched request, and drives mem_we equal to the latched we.
REQ-028 DATA: on a read, load cpu_rdata with mem_rdata; on a write, leave cpu_rdata unchanged; go to ACK; a video grant is allowed in this cycle.
REQ-029 ACK: cpu_ready=1 for this cycle only; go to IDLE; a video grant is allowed in this cycle.
REQ-030 CPU inputs are sampled only in IDLE; changes to them in PEND, DATA or ACK are ignored.
REQ-031 A cpu_req still high in the first IDLE cycle after ACK starts a new access.
REQ-032 Video grant: mem_address=vid_address and mem_we=0; vid_valid=1 in the following cycle.
REQ-033 Video request preempted by a CPU starvation grant: vid_valid=0 and vid_miss=1 in the following cycle; vid_miss_count increments and saturates at 255.
REQ-034 No grant: mem_we=0 and mem_address=vid_address.
REQ-035 Minimum CPU latency: cpu_req sampled in IDLE at cycle T gives grant at T+1 and cpu_ready at T+3.
REQ-036 Simultaneous vid_req and a CPU grant in the same cycle occur only at wait_cnt==STARVE_LIMIT.
REQ-037 mem_we=1 only during a CPU-write grant cycle.

Reset
REQ-038 While reset=1: FSM goes to IDLE, and wait_cnt, cpu_rdata, cpu_ready, vid_valid, vid_miss and vid_miss_count are all cleared to 0.
REQ-039 While reset=1: no grant is issued and mem_we=0.
REQ-040 Reset asserted in PEND, DATA or ACK aborts the access: no cpu_ready pulse follows, and an ungranted write never reaches memory.
REQ-041 In the first cycle after reset deasserts the FSM is in IDLE and samples cpu_req.

Verification
REQ-042 Idle-bus CPU read: RAM[0x00100]=0xA5, vid_req=0, CPU reads 0x00100 -> mem_address=0x00100 at T+1; cpu_rdata=0xA5 with cpu_ready=1 at T+3; no other cpu_ready pulse.
REQ-043 CPU write under alternating vid_req (1,0,1,0...) -> write granted in the first vid_req=0 PEND cycle with mem_we=1 and mem_address=cpu_address; every vid_req is followed by vid_valid=1; vid_miss_count stays 0.
REQ-044 Starvation: vid_req held at 1 and STARVE_LIMIT=15 -> 15 video grants, then a CPU grant on the 16th PEND cycle; vid_miss pulses once; vid_miss_count=1; cpu_ready follows 2 cycles later.
REQ-045 Saturation: 260 forced preemptions -> vid_miss_count=255 and held.
REQ-046 Reset in PEND while a write is pending -> mem_we never asserts; cpu_ready stays 0; all outputs are 0 on the next cycle.
REQ-047 Back-to-back: cpu_req held high across two reads -> second access sampled in the IDLE cycle after ACK; ready pulses separated by 4 cycles when vid_req=0.
